// File: rtl/bin_ascii_tx.sv
// Prints one WIDTH-bit word per frame as ASCII '0'/'1' digits, MSB first, then a terminator.
// A flagged input word prints ERR_CHAR followed by the terminator instead of digits.
module bin_ascii_tx #(
  parameter int unsigned WIDTH    = 4,
  parameter logic [7:0]  NL_CHAR  = 8'h0A,
  parameter logic [7:0]  ERR_CHAR = 8'h45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             frame_done
);

  // state | meaning
  // IDLE  | waiting for a word, in_ready high
  // BITS  | presenting digit bytes, cnt_q = digits left after the current one
  // ERR   | presenting ERR_CHAR for a flagged word
  // TERM  | presenting the terminator byte

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BITS, ERR, TERM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             frame_done_q, frame_done_d;
  logic [WIDTH-1:0] shifted;
  logic             xfer;

  function automatic logic [7:0] digit(input logic b);
    return b ? 8'h31 : 8'h30;
  endfunction

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign xfer       = out_valid_q && out_ready;
  assign shifted    = shift_q << 1;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d     = in_data;
          out_valid_d = 1'b1;
          if (in_err) begin
            state_d    = ERR;
            out_data_d = ERR_CHAR;
          end else begin
            state_d    = BITS;
            cnt_d      = CNT_LAST;
            out_data_d = digit(in_data[WIDTH-1]);
          end
        end
      end
      BITS: begin
        if (xfer) begin
          shift_d = shifted;
          if (cnt_q != '0) begin
            cnt_d      = cnt_q - CW'(1);
            out_data_d = digit(shifted[WIDTH-1]);
          end else begin
            state_d    = TERM;
            out_data_d = NL_CHAR;
          end
        end
      end
      ERR: begin
        if (xfer) begin
          state_d    = TERM;
          out_data_d = NL_CHAR;
        end
      end
      TERM: begin
        if (xfer) begin
          state_d      = IDLE;
          out_valid_d  = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
